lvds_rx_deframer: RTL and testbench

- Receive-side counterpart of the DDR serializer. Deserializes the 2-bit-per-clock LVDS stream (MSB dibit first) into 32-bit I/Q words.
- Locks to per-sample sync dibits: I sync at word bits [31:30], Q sync at word bits [15:14].
- Pushes each complete, validated word into the RX FIFO.
- Sits between the LVDS input buffers and the RX async FIFO. Runs entirely in the DDR clock domain.

---
 rtl/lvds_rx_deframer_if.sv | 31 +++
 rtl/lvds_rx_deframer.sv | 164 ++++++++++++++++
 tb/tb_lvds_rx_deframer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_rx_deframer_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lvds_rx_deframer_if
// Write-side bundle between the LVDS deframer and the RX async FIFO.
//   o_fifo_write_clk : FIFO write clock (the DDR clock, forwarded)
//   o_fifo_push      : one-cycle write strobe
//   o_fifo_data      : 32-bit word {SYNC_I, I[13:0], SYNC_Q, Q[13:0]}
//   i_fifo_full      : FIFO full flag, returned to the deframer
// Signal names are given from the deframer's point of view.
// master = deframer, slave = FIFO.
// ---------------------------------------------------------------------------
interface lvds_rx_deframer_if;
    logic        o_fifo_write_clk;
    logic        o_fifo_push;
    logic [31:0] o_fifo_data;
    logic        i_fifo_full;

    modport master (
        output o_fifo_write_clk,
        output o_fifo_push,
        output o_fifo_data,
        input  i_fifo_full
    );

    modport slave (
        input  o_fifo_write_clk,
        input  o_fifo_push,
        input  o_fifo_data,
        output i_fifo_full
    );
endinterface

// File: rtl/lvds_rx_deframer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lvds_rx_deframer
// Deserialises a 2-bit-per-clock LVDS stream (MSB dibit first) into 32-bit
// I/Q words. A word starts on SYNC_I and must carry SYNC_Q at dibit 8.
// Complete words are pushed into the RX FIFO. The block runs entirely in the
// DDR clock domain.
// Ports:
//   i_ddr_clk      : DDR-domain clock, rising edge
//   i_rst          : asynchronous active-high reset
//   i_ddr_data     : one dibit per clock, bit 1 is the more significant
//   i_rx_enable    : reception gate; low forces IDLE and drops a partial word
//   fifo           : FIFO write bundle (write clock, push, data, full)
//   o_overflow_cnt : saturating count of words dropped on FIFO full
//   o_sync_err_cnt : saturating count of frames aborted on a bad SYNC_Q
//   o_debug_state  : registered state, 00 IDLE / 01 I_PHASE / 10 Q_PHASE
// ---------------------------------------------------------------------------
module lvds_rx_deframer #(
    parameter logic [1:0] SYNC_I = 2'b10,
    parameter logic [1:0] SYNC_Q = 2'b01,
    parameter int         CNT_W  = 8
) (
    input  logic               i_ddr_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_ddr_data,
    input  logic               i_rx_enable,
    lvds_rx_deframer_if.master fifo,
    output logic [CNT_W-1:0]   o_overflow_cnt,
    output logic [CNT_W-1:0]   o_sync_err_cnt,
    output logic [1:0]         o_debug_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_I    = 2'b01,
        ST_Q    = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    state_t             r_state;
    logic [3:0]         r_k;          // index of the dibit expected next
    logic [29:0]        r_shift;      // dibits 0..14 of the word being built
    logic               r_push;
    logic [31:0]        r_data;
    logic [CNT_W-1:0]   r_ovf_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    state_t             w_state_next;
    logic               w_shift;      // current dibit belongs to the word
    logic               w_sync_err;   // dibit 8 is not SYNC_Q
    logic               w_word_done;  // current dibit is dibit 15

    assign fifo.o_fifo_write_clk = i_ddr_clk;
    assign fifo.o_fifo_push      = r_push;
    assign fifo.o_fifo_data      = r_data;
    assign o_overflow_cnt        = r_ovf_cnt;
    assign o_sync_err_cnt        = r_err_cnt;

    // State register
    always_ff @(posedge i_ddr_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-dibit decode
    always_comb begin
        w_state_next = r_state;
        w_shift      = 1'b0;
        w_sync_err   = 1'b0;
        w_word_done  = 1'b0;
        if (!i_rx_enable) begin
            // Disable drops any partial word silently; it is not a sync error.
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_ddr_data == SYNC_I) begin
                        w_shift      = 1'b1;
                        w_state_next = ST_I;
                    end
                end
                ST_I: begin
                    w_shift = 1'b1;
                    if (r_k == 4'd7) begin
                        w_state_next = ST_Q;
                    end
                end
                ST_Q: begin
                    if ((r_k == 4'd8) && (i_ddr_data != SYNC_Q)) begin
                        // The offending dibit is consumed here, so it is never
                        // reconsidered as the start of a new word.
                        w_sync_err   = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_shift = 1'b1;
                        if (r_k == 4'd15) begin
                            w_word_done  = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        o_debug_state = r_state;
    end

    // Datapath: shift register, dibit index, word output and counters
    always_ff @(posedge i_ddr_clk or posedge i_rst) begin
        if (i_rst) begin
            r_k       <= 4'd0;
            r_shift   <= 30'd0;
            r_push    <= 1'b0;
            r_data    <= 32'd0;
            r_ovf_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_push <= 1'b0;

            if (w_state_next == ST_IDLE) begin
                r_k <= 4'd0;
            end else if (w_shift) begin
                r_k <= r_k + 4'd1;
            end

            if (w_shift) begin
                if (r_state == ST_IDLE) begin
                    r_shift <= {28'd0, SYNC_I};
                end else begin
                    r_shift <= {r_shift[27:0], i_ddr_data};
                end
            end

            // Full is only looked at on the dibit-15 edge.
            if (w_word_done) begin
                r_data <= {r_shift, i_ddr_data};
                r_push <= ~fifo.i_fifo_full;
                if (fifo.i_fifo_full) begin
                    r_ovf_cnt <= sat_inc(r_ovf_cnt);
                end
            end

            if (w_sync_err) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_lvds_rx_deframer.sv
`timescale 1ns/1ps
module tb_lvds_rx_deframer;

    localparam logic [31:0] WORD_A = 32'h92344ABC;
    localparam logic [31:0] WORD_B = 32'h80004000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ddr;
    logic       en;
    logic [7:0] ovf_cnt;
    logic [7:0] err_cnt;
    logic [1:0] dbg;

    lvds_rx_deframer_if fifo_if();

    lvds_rx_deframer #(
        .SYNC_I(2'b10),
        .SYNC_Q(2'b01),
        .CNT_W (8)
    ) dut (
        .i_ddr_clk      (clk),
        .i_rst          (rst),
        .i_ddr_data     (ddr),
        .i_rx_enable    (en),
        .fifo           (fifo_if),
        .o_overflow_cnt (ovf_cnt),
        .o_sync_err_cnt (err_cnt),
        .o_debug_state  (dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard: every push must match the oldest expected word and arrive
    // on the cycle predicted when its last dibit was driven.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (!rst && fifo_if.o_fifo_push) begin
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_push", 32'(fifo_if.o_fifo_push), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk_eq("push_data", fifo_if.o_fifo_data, e.w);
                chk_eq("push_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d expected pushes pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [1:0] d, input logic e, input logic f);
        @(negedge clk);
        ddr = d;
        en  = e;
        fifo_if.i_fifo_full = f;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b00, 1'b1, 1'b0);
    endtask

    task automatic send_prefix(input logic [31:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            logic [1:0] d;
            d = w[31-2*k -: 2];
            drive(d, 1'b1, 1'b0);
        end
    endtask

    // full15 drives i_fifo_full on dibit 15, full_other on all other dibits.
    task automatic send_word(input logic [31:0] w, input logic full15,
                             input logic full_other, input logic chk_st);
        for (int k = 0; k < 16; k++) begin
            logic [1:0] d;
            d = w[31-2*k -: 2];
            drive(d, 1'b1, (k == 15) ? full15 : full_other);
            if (k == 15 && !full15) exp_q.push_back('{w: w, cyc: cyc + 1});
            if (chk_st) begin
                after_edge();
                chk_eq("state_in_word", 32'(dbg), (k < 7) ? 32'd1 : (k < 15) ? 32'd2 : 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        ddr = 2'b00;
        fifo_if.i_fifo_full = 1'b0;
        #2;
        chk_eq("rst_push", 32'(fifo_if.o_fifo_push), 32'd0);
        chk_eq("rst_data", fifo_if.o_fifo_data, 32'd0);
        chk_eq("rst_ovf", 32'(ovf_cnt), 32'd0);
        chk_eq("rst_err", 32'(err_cnt), 32'd0);
        chk_eq("rst_state", 32'(dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // Single word
        send_word(WORD_A, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Back-to-back words, no gap
        send_word(WORD_A, 1'b0, 1'b0, 1'b0);
        send_word(WORD_B, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk_eq("b2b_err", 32'(err_cnt), 32'd0);

        // Idle filler, then a word
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 1'b1, 1'b0);
            after_edge();
            chk_eq("filler_state", 32'(dbg), 32'd0);
        end
        send_word(WORD_A, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Bad SYNC_Q (11) aborts the frame
        send_prefix(WORD_A, 8);
        drive(2'b11, 1'b1, 1'b0);
        after_edge();
        chk_eq("syncq_bad_state", 32'(dbg), 32'd0);
        chk_eq("syncq_bad_err", 32'(err_cnt), 32'd1);
        send_word(WORD_B, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Bad SYNC_Q that looks like SYNC_I must not start a new frame
        send_prefix(WORD_A, 8);
        drive(2'b10, 1'b1, 1'b0);
        after_edge();
        chk_eq("syncq_as_synci_state", 32'(dbg), 32'd0);
        chk_eq("syncq_as_synci_err", 32'(err_cnt), 32'd2);
        send_word(WORD_A, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Full outside dibit 15 is ignored
        send_word(WORD_B, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk_eq("full_ignored_ovf", 32'(ovf_cnt), 32'd0);

        // Full at dibit 15: words dropped, counter saturates
        for (int i = 0; i < 300; i++) begin
            send_word(WORD_A, 1'b1, 1'b0, 1'b0);
            if (i == 253) begin
                after_edge();
                chk_eq("ovf_254", 32'(ovf_cnt), 32'd254);
            end
        end
        after_edge();
        chk_eq("ovf_sat", 32'(ovf_cnt), 32'd255);
        idle(2);
        chk_eq("ovf_err_unchanged", 32'(err_cnt), 32'd2);

        // Enable dropped at dibit 5
        send_prefix(WORD_A, 5);
        drive(WORD_A[21:20], 1'b0, 1'b0);
        after_edge();
        chk_eq("en_drop_state", 32'(dbg), 32'd0);
        chk_eq("en_drop_err", 32'(err_cnt), 32'd2);
        chk_eq("en_drop_ovf", 32'(ovf_cnt), 32'd255);
        idle(2);

        // Asynchronous reset mid-word
        drive(2'b10, 1'b1, 1'b0);
        drive(2'b01, 1'b1, 1'b0);
        after_edge();
        chk_eq("pre_rst_state", 32'(dbg), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("arst_state", 32'(dbg), 32'd0);
        chk_eq("arst_ovf", 32'(ovf_cnt), 32'd0);
        chk_eq("arst_err", 32'(err_cnt), 32'd0);
        chk_eq("arst_push", 32'(fifo_if.o_fifo_push), 32'd0);
        chk_eq("arst_data", fifo_if.o_fifo_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        after_edge();
        chk_eq("post_rst_state", 32'(dbg), 32'd0);
        chk_eq("wr_clk_high", 32'(fifo_if.o_fifo_write_clk), 32'(clk));
        send_word(WORD_B, 1'b0, 1'b0, 1'b1);
        idle(3);
        chk_eq("post_rst_err", 32'(err_cnt), 32'd0);
        chk_eq("pending_pushes", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
